// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the regfile writeback path.
package regfile_wb_arbiter_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    typedef struct packed {
        logic [DEF_REG_AW-1:0] addr;
        logic [DEF_XLEN-1:0]   data;
    } wb_req_t;

    // Width of an index into n items; never zero so ports stay legal for n=1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo N.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int s;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        s       = 0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            if (!gnt_vld && req[s]) begin
                gnt_vld = 1'b1;
                gnt[s]  = 1'b1;
                gnt_idx = IW'(s);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// One-entry holding slot per writeback requester, drained round-robin onto
// the single regfile write port; exports a pending-write bitmap for hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NB_REQ = 2,
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NB_REQ-1:0]        i_req_valid,
    output logic [NB_REQ-1:0]        o_req_ready,
    input  logic [NB_REQ*REG_AW-1:0] i_req_addr,
    input  logic [NB_REQ*XLEN-1:0]   i_req_data,
    output logic                     o_wr_en,
    output logic [REG_AW-1:0]        o_wr_addr,
    output logic [XLEN-1:0]          o_wr_data,
    output logic [2**REG_AW-1:0]     o_busy,
    output logic                     o_idle
);

    localparam int PW = idx_w(NB_REQ);

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } slot_t;

    logic [NB_REQ-1:0]             full;
    slot_t [NB_REQ-1:0]            slot;
    logic [PW-1:0]                 rr_ptr;
    logic [NB_REQ-1:0]             gnt;
    logic [PW-1:0]                 gnt_idx;
    logic                          gnt_vld;
    logic [NB_REQ-1:0][REG_AW-1:0] req_addr;
    logic [NB_REQ-1:0][XLEN-1:0]   req_data;
    logic [NB_REQ-1:0]             accept;

    assign req_addr = i_req_addr;
    assign req_data = i_req_data;

    rr_arbiter #(.N(NB_REQ), .IW(PW)) u_arb (
        .req     (full),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // A request may not overtake a buffered write to the same register, and
    // same-cycle collisions resolve to the lowest index to keep WAW order.
    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            o_req_ready[k] = ~full[k] | gnt[k];
            for (int j = 0; j < NB_REQ; j++) begin
                if (j != k && req_addr[k] != '0) begin
                    if (full[j] && !gnt[j] && slot[j].addr == req_addr[k])
                        o_req_ready[k] = 1'b0;
                    if (j < k && i_req_valid[j] && req_addr[j] == req_addr[k])
                        o_req_ready[k] = 1'b0;
                end
            end
        end
    end

    assign accept = i_req_valid & o_req_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full   <= '0;
            slot   <= '0;
            rr_ptr <= '0;
        end else begin
            for (int k = 0; k < NB_REQ; k++) begin
                // x0 writes are swallowed: accepted but never buffered.
                if (accept[k] && req_addr[k] != '0) begin
                    full[k]      <= 1'b1;
                    slot[k].addr <= req_addr[k];
                    slot[k].data <= req_data[k];
                end else if (gnt[k]) begin
                    full[k] <= 1'b0;
                end
            end
            if (gnt_vld)
                rr_ptr <= (gnt_idx == PW'(NB_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    assign o_wr_en   = gnt_vld;
    assign o_wr_addr = gnt_vld ? slot[gnt_idx].addr : '0;
    assign o_wr_data = gnt_vld ? slot[gnt_idx].data : '0;
    assign o_idle    = ~|full;

    always_comb begin
        o_busy = '0;
        for (int k = 0; k < NB_REQ; k++)
            if (full[k]) o_busy[slot[k].addr] = 1'b1;
        o_busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a slot-level reference model
// and a behavioural regfile fed by the write port.
module tb_regfile_wb_arbiter;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NR   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      valid;
    logic [N-1:0]      ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*XLEN-1:0] req_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [NR-1:0]     busy;
    logic              idle;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NB_REQ(N), .XLEN(XLEN), .REG_AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (valid),
        .o_req_ready (ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_busy      (busy),
        .o_idle      (idle)
    );

    // Regfile stand-in: commits whatever the write port presents.
    logic [XLEN-1:0] rf [NR] = '{default: '0};
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit              m_full [N];
    int              m_addr [N];
    logic [XLEN-1:0] m_data [N];
    int              m_ptr;

    function automatic int a_of(input int k);
        return int'(req_addr[k*AW +: AW]);
    endfunction

    function automatic logic [XLEN-1:0] d_of(input int k);
        return req_data[k*XLEN +: XLEN];
    endfunction

    function automatic void model_eval(output int g, output logic [N-1:0] rdy);
        g = -1;
        for (int off = 0; off < N; off++)
            if (g < 0 && m_full[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        for (int k = 0; k < N; k++) begin
            bit ok;
            ok = !m_full[k] || g == k;
            for (int j = 0; j < N; j++) begin
                if (j != k && a_of(k) != 0) begin
                    if (m_full[j] && j != g && m_addr[j] == a_of(k)) ok = 0;
                    if (j < k && valid[j] && a_of(j) == a_of(k)) ok = 0;
                end
            end
            rdy[k] = ok;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        logic [N-1:0] rdy;
        if (rst) begin
            for (int k = 0; k < N; k++) m_full[k] <= 1'b0;
            m_ptr <= 0;
        end else begin
            model_eval(g, rdy);
            for (int k = 0; k < N; k++) begin
                if (valid[k] && rdy[k] && a_of(k) != 0) begin
                    m_full[k] <= 1'b1;
                    m_addr[k] <= a_of(k);
                    m_data[k] <= d_of(k);
                end else if (k == g) begin
                    m_full[k] <= 1'b0;
                end
            end
            if (g >= 0) m_ptr <= (g + 1) % N;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] rdy;
        logic [NR-1:0] eb;
        bit any;
        model_eval(g, rdy);
        eb  = '0;
        any = 0;
        for (int k = 0; k < N; k++)
            if (m_full[k]) begin eb[m_addr[k]] = 1'b1; any = 1; end
        check("m_wr_en",   wr_en,   (g >= 0) ? 1 : 0);
        check("m_wr_addr", wr_addr, (g >= 0) ? m_addr[g] : 0);
        check("m_wr_data", wr_data, (g >= 0) ? m_data[g] : 0);
        check("m_busy",    busy,    eb);
        check("m_idle",    idle,    any ? 0 : 1);
        check("m_ready",   ready,   rdy);
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input int k, input bit v, input int a, input logic [XLEN-1:0] d);
        valid[k] = v;
        req_addr[k*AW +: AW]   = AW'(a);
        req_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g7, g8;
        logic [N-1:0] r;
        logic [XLEN-1:0] d0, d1, last0, last1;
        valid = '0; req_addr = '0; req_data = '0;
        tick(); tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_busy",  busy, 0);
        check("rst_idle",  idle, 1);
        check("rst_ready", ready, 2'b11);
        rst = 1'b0;

        // 1: single write r3=42
        set_req(0, 1, 3, 42);
        tick();
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 3);
        check("t1_wr_data", wr_data, 42);
        check("t1_busy3_on", busy[3], 1);
        tick();
        @(negedge clk);
        check("t1_busy3_off", busy[3], 0);
        check("t1_r3", rf[3], 42);

        // 2: simultaneous from reset, slot 0 first
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 1, 4, 512);
        set_req(1, 1, 5, 7);
        tick();
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        @(negedge clk);
        check("t2_first_addr", wr_addr, 4);
        check("t2_first_data", wr_data, 512);
        tick();
        @(negedge clk);
        check("t2_second_addr", wr_addr, 5);
        check("t2_second_data", wr_data, 7);
        tick();
        @(negedge clk);
        check("t2_idle", idle, 1);
        check("t2_r4", rf[4], 512);
        check("t2_r5", rf[5], 7);

        // 4: WAW guard across requesters on r6
        tick();
        set_req(0, 1, 9, 5);
        set_req(1, 1, 6, 1);
        tick();
        set_req(0, 1, 6, 2);
        set_req(1, 0, 0, 0);
        @(negedge clk);
        check("t4_ready0_blocked", ready[0], 0);
        check("t4_grant_r9", wr_addr, 9);
        tick();
        @(negedge clk);
        check("t4_ready0_free", ready[0], 1);
        check("t4_grant_r6_old", wr_data, 1);
        tick();
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("t4_grant_r6_new", wr_data, 2);
        tick();
        @(negedge clk);
        check("t4_r6", rf[6], 2);
        check("t4_r9", rf[9], 5);

        // 5: x0 write is swallowed
        tick();
        set_req(0, 1, 0, 32'hDEADBEEF);
        @(negedge clk);
        check("t5_ready", ready[0], 1);
        tick();
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("t5_wr_en", wr_en, 0);
        check("t5_busy", busy, 0);
        check("t5_idle", idle, 1);
        tick();
        @(negedge clk);
        check("t5_r0", rf[0], 0);

        // 3: both requesters saturating, fairness
        tick();
        g7 = 0; g8 = 0;
        d0 = 1000; d1 = 2000; last0 = 0; last1 = 0;
        set_req(0, 1, 7, d0);
        set_req(1, 1, 8, d1);
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            r = ready;
            if (i > 0 && wr_en) begin
                if (wr_addr == 7) g7++;
                if (wr_addr == 8) g8++;
            end
            tick();
            if (r[0]) begin last0 = d0; d0 = d0 + 1; set_req(0, 1, 7, d0); end
            if (r[1]) begin last1 = d1; d1 = d1 + 1; set_req(1, 1, 8, d1); end
        end
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        tick(); tick(); tick();
        @(negedge clk);
        check("t3_grants0", g7, 50);
        check("t3_grants1", g8, 50);
        check("t3_r7", rf[7], last0);
        check("t3_r8", rf[8], last1);
        check("t3_idle", idle, 1);

        // 6: async reset with both slots full
        tick();
        set_req(0, 1, 10, 'h55);
        tick();
        set_req(0, 0, 0, 0);
        tick(); tick();
        set_req(0, 1, 10, 'h111);
        set_req(1, 1, 11, 'h222);
        tick();
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_wr_en", wr_en, 0);
        check("t6_busy", busy, 0);
        check("t6_idle", idle, 1);
        check("t6_ready", ready, 2'b11);
        tick();
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("t6_r10", rf[10], 'h55);
        check("t6_r11", rf[11], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of regfile_2r1w between NB_REQ writeback requesters (e.g. ALU and LSU).
- Each requester has a one-entry holding slot. A round-robin arbiter drains the slots onto the regfile write port, one write per cycle.
- Exports a per-register pending-write bitmap so the issue stage can stall on hazards against buffered writes.

Parameters:
NB_REQ, 2, number of writeback requesters (2..4)
XLEN, 32, data width of the register file
REG_AW, 5, register address width; NB_REGS = 2**REG_AW

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  reset, asynchronous, active-high
i_req_valid  input  NB_REQ  per-requester write request valid
o_req_ready  output  NB_REQ  per-requester ready; transfer when valid & ready at the rising edge
i_req_addr  input  NB_REQ*REG_AW  per-requester destination register, requester k at bits [k*REG_AW +: REG_AW]
i_req_data  input  NB_REQ*XLEN  per-requester write data, same packing
o_wr_en  output  1  to regfile i_wr_en
o_wr_addr  output  REG_AW  to regfile i_wr_addr
o_wr_data  output  XLEN  to regfile i_wr_data
o_busy  output  NB_REGS  bit r set while any slot holds a pending write to register r
o_idle  output  1  high when all slots are empty

Behaviour:
- State:
  - per-slot full flag, addr and data;
  - round-robin pointer rr_ptr, range 0..NB_REQ-1.
- Reset (async, i_rst=1): all slots empty, rr_ptr=0.
  - Outputs during reset: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_idle=1.
  - o_req_ready follows the ready rule below, so it is all-ones during reset.
  - Reset mid-operation discards all buffered writes; none reaches the regfile.
- Arbitration (combinational from registered state):
  - Among full slots, grant the first one at or after rr_ptr, searching modulo NB_REQ.
  - At most one grant per cycle.
  - On a grant to slot g: rr_ptr <= (g+1) mod NB_REQ at the next edge. With no grant, rr_ptr holds.
- Write port:
  - o_wr_en=1 iff there is a grant.
  - o_wr_addr and o_wr_data come from the granted slot; both are 0 when there is no grant.
  - The regfile commits on the same edge that frees the granted slot.
- Latency:
  - A request accepted at edge N is visible on the write port during cycle N..N+1 and written at edge N+1 at the earliest.
  - Under contention the worst-case wait is NB_REQ-1 extra cycles (round-robin fairness, no starvation).
- Ready rule for requester k, all three conditions required:
  - slot k is empty, or slot k is granted this cycle (back-to-back at 1 write/cycle per requester);
  - no other full, non-granted slot holds the same i_req_addr[k] with that address non-zero. This ordering guard enforces write-after-write order across requesters;
  - i_rst=0 is not required; ready is combinational.
- x0 handling:
  - A request to address 0 is accepted under the normal ready rule but never fills a slot.
  - It never produces o_wr_en and never sets o_busy[0].
  - o_busy[0] is always 0.
- o_busy:
  - OR over full slots of a one-hot of the slot address.
  - A slot granted this cycle still shows busy until the edge.
- o_idle = no slot full.
- Simultaneous events:
  - Accept and grant on the same slot in the same cycle: the slot reloads with the new request and stays full.
  - Multiple requests to the same non-zero address in the same cycle from empty slots: only the lowest-index requester is ready; the others stall until it is granted.
- Assumption on callers: i_req_* is held stable while valid & !ready.

Decomposition:
- Add to the shared core package:
  - typedef wb_req_t {addr [REG_AW-1:0], data [XLEN-1:0]};
  - constants REG_AW and XLEN defaults.
- One natural sub-module: rr_arbiter (NB_REQ request vector plus pointer in; one-hot grant and index out; purely combinational). It is reusable by the memory-port arbiter.
- Slot storage and ready logic stay in regfile_wb_arbiter.
- The top-level bench instantiates regfile_wb_arbiter driving regfile_2r1w and checks through the read ports.

Test Plan:
1. Reset, then req0 writes r3=42 at edge 1 -> o_wr_en=1, o_wr_addr=3 during cycle 1. A read of r3 after edge 2 returns 42. o_busy[3] is high for exactly one cycle.
2. req0 writes r4=512 and req1 writes r5=7 in the same cycle from reset (rr_ptr=0) -> r4 is written first, r5 next cycle. Then rr_ptr=0 again; o_idle returns high.
3. Both requesters held valid continuously with distinct addresses -> grants alternate 0,1,0,1; each o_req_ready pulses every other cycle; neither starves over 100 cycles.
4. req1 is pending r6=1 and req0 issues r6=2 -> o_req_ready[0]=0 until r6=1 is granted; final r6=2.
5. A write to r0 with data 0xDEADBEEF -> accepted, o_wr_en stays 0, o_busy=0, and r0 reads 0.
6. Assert i_rst asynchronously with both slots full -> o_wr_en drops immediately, o_busy=0. After release, the target registers keep their previous values.
